// File: rtl/cuckoo_pkg.sv
// Shared definitions for the cuckoo lookup pipeline: default sizes, T3 entry
// layout and the address hash used by both tables.
package cuckoo_pkg;

    localparam int DEF_NUM_CH = 2;
    localparam int DEF_HASH_W = 10;
    localparam int DEF_IDX_W  = 9;
    localparam int DEF_KEY_W  = 8;
    localparam int DEF_SUF_W  = 2;

    // Hash arithmetic runs at a fixed wide width and is truncated by the caller;
    // carries only propagate upward, so truncating afterwards is exact.
    localparam int HASH_CALC_W = 32;

    // T3 entry = {key, suffix}: suffix occupies the low bits.
    localparam int T3_SUF_LSB = 0;

    function automatic int t3_key_lsb(input int suf_w);
        return suf_w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [HASH_CALC_W-1:0] cuckoo_hash(
        input logic [HASH_CALC_W-1:0] pre,
        input logic [HASH_CALC_W-1:0] hb
    );
        return ((pre << 5'd3) + (pre >> 5'd3) + hb) ^ pre;
    endfunction

endpackage

// File: rtl/cuckoo_lookup_ch.sv
// One lookup channel: hash stage, L1 indirection RAM, dual-read T3 RAM and
// key compare, with the compare byte and valid carried alongside.
module cuckoo_lookup_ch
    import cuckoo_pkg::*;
#(
    parameter int HASH_W = DEF_HASH_W,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int KEY_W  = DEF_KEY_W,
    parameter int SUF_W  = DEF_SUF_W,
    parameter int CFG_W  = max_int(DEF_IDX_W, DEF_KEY_W + DEF_SUF_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [HASH_W-1:0] pre_t1,
    input  logic [HASH_W-1:0] pre_t2,
    input  logic [KEY_W-1:0]  hash_byte,
    input  logic [KEY_W-1:0]  cmp_byte,
    input  logic              l1_we,
    input  logic              t3_we,
    input  logic [HASH_W:0]   cfg_addr,
    input  logic [CFG_W-1:0]  cfg_data,
    output logic              out_valid,
    output logic [1:0]        hit,
    output logic [SUF_W-1:0]  suffix
);

    localparam int T3_W    = KEY_W + SUF_W;
    localparam int KEY_LSB = t3_key_lsb(SUF_W);
    localparam int L1_DEPTH = 2 ** (HASH_W + 1);
    localparam int T3_DEPTH = 2 ** IDX_W;

    logic [IDX_W-1:0] l1_mem [L1_DEPTH];
    logic [T3_W-1:0]  t3_mem [T3_DEPTH];

    logic [HASH_W-1:0] addr_t1_s;
    logic [HASH_W-1:0] addr_t2_s;

    logic              v1_r;
    logic [HASH_W-1:0] a1_r;
    logic [HASH_W-1:0] a2_r;
    logic [KEY_W-1:0]  c1_r;

    logic              v2_r;
    logic [IDX_W-1:0]  l1a_r;
    logic [IDX_W-1:0]  l1b_r;
    logic [KEY_W-1:0]  c2_r;

    logic              v3_r;
    logic [T3_W-1:0]   t3a_r;
    logic [T3_W-1:0]   t3b_r;
    logic [KEY_W-1:0]  c3_r;

    logic [KEY_W-1:0]  key_a_s;
    logic [KEY_W-1:0]  key_b_s;
    logic [SUF_W-1:0]  suf_a_s;
    logic [SUF_W-1:0]  suf_b_s;
    logic [1:0]        hit_s;
    logic [SUF_W-1:0]  suf_s;

    assign addr_t1_s = HASH_W'(cuckoo_hash(HASH_CALC_W'(pre_t1), HASH_CALC_W'(hash_byte)));
    assign addr_t2_s = HASH_W'(cuckoo_hash(HASH_CALC_W'(pre_t2), HASH_CALC_W'(hash_byte)));

    assign key_a_s = t3a_r[KEY_LSB +: KEY_W];
    assign key_b_s = t3b_r[KEY_LSB +: KEY_W];
    assign suf_a_s = t3a_r[T3_SUF_LSB +: SUF_W];
    assign suf_b_s = t3b_r[T3_SUF_LSB +: SUF_W];

    // Table programming; reads in the pipeline block see the pre-write value.
    always_ff @(posedge clk) begin
        if (l1_we) begin
            l1_mem[cfg_addr] <= cfg_data[IDX_W-1:0];
        end
        if (t3_we) begin
            t3_mem[cfg_addr[IDX_W-1:0]] <= cfg_data[T3_W-1:0];
        end
    end

    // Way A has priority for the suffix when both ways match.
    always_comb begin
        hit_s = 2'b00;
        suf_s = '0;
        if (v3_r) begin
            hit_s[0] = (key_a_s == c3_r);
            hit_s[1] = (key_b_s == c3_r);
            if (hit_s[0]) begin
                suf_s = suf_a_s;
            end else if (hit_s[1]) begin
                suf_s = suf_b_s;
            end else begin
                suf_s = '0;
            end
        end else begin
            hit_s = 2'b00;
            suf_s = '0;
        end
    end

    // Four-stage pipeline; enable low freezes every stage, reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r      <= 1'b0;
            a1_r      <= '0;
            a2_r      <= '0;
            c1_r      <= '0;
            v2_r      <= 1'b0;
            l1a_r     <= '0;
            l1b_r     <= '0;
            c2_r      <= '0;
            v3_r      <= 1'b0;
            t3a_r     <= '0;
            t3b_r     <= '0;
            c3_r      <= '0;
            out_valid <= 1'b0;
            hit       <= 2'b00;
            suffix    <= '0;
        end else if (enable) begin
            v1_r      <= in_valid;
            a1_r      <= addr_t1_s;
            a2_r      <= addr_t2_s;
            c1_r      <= cmp_byte;
            v2_r      <= v1_r;
            l1a_r     <= l1_mem[{1'b0, a1_r}];
            l1b_r     <= l1_mem[{1'b1, a2_r}];
            c2_r      <= c1_r;
            v3_r      <= v2_r;
            t3a_r     <= t3_mem[l1a_r];
            t3b_r     <= t3_mem[l1b_r];
            c3_r      <= c2_r;
            out_valid <= v3_r;
            hit       <= hit_s;
            suffix    <= suf_s;
        end
    end

endmodule

// File: rtl/cuckoo_lookup_pipe.sv
// Multi-channel cuckoo lookup pipeline: one independent lookup channel per
// NUM_CH, sharing a single table-programming port.
module cuckoo_lookup_pipe
    import cuckoo_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int HASH_W = DEF_HASH_W,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int KEY_W  = DEF_KEY_W,
    parameter int SUF_W  = DEF_SUF_W,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CFG_W = max_int(IDX_W, KEY_W + SUF_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*HASH_W-1:0] pre_t1,
    input  logic [NUM_CH*HASH_W-1:0] pre_t2,
    input  logic [NUM_CH*KEY_W-1:0]  hash_byte,
    input  logic [NUM_CH*KEY_W-1:0]  cmp_byte,
    input  logic                     cfg_we,
    input  logic                     cfg_sel,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [HASH_W:0]          cfg_addr,
    input  logic [CFG_W-1:0]         cfg_data,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH*2-1:0]      hit,
    output logic [NUM_CH*SUF_W-1:0]  suffix
);

    logic [NUM_CH-1:0] l1_we_s;
    logic [NUM_CH-1:0] t3_we_s;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // An out-of-range cfg_ch matches no channel, so the write is dropped.
        assign l1_we_s[i] = cfg_we & ~rst & ~cfg_sel & (cfg_ch == CH_W'(i));
        assign t3_we_s[i] = cfg_we & ~rst &  cfg_sel & (cfg_ch == CH_W'(i));

        cuckoo_lookup_ch #(
            .HASH_W (HASH_W),
            .IDX_W  (IDX_W),
            .KEY_W  (KEY_W),
            .SUF_W  (SUF_W),
            .CFG_W  (CFG_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .enable    (enable),
            .in_valid  (in_valid[i]),
            .pre_t1    (pre_t1[i*HASH_W +: HASH_W]),
            .pre_t2    (pre_t2[i*HASH_W +: HASH_W]),
            .hash_byte (hash_byte[i*KEY_W +: KEY_W]),
            .cmp_byte  (cmp_byte[i*KEY_W +: KEY_W]),
            .l1_we     (l1_we_s[i]),
            .t3_we     (t3_we_s[i]),
            .cfg_addr  (cfg_addr),
            .cfg_data  (cfg_data),
            .out_valid (out_valid[i]),
            .hit       (hit[i*2 +: 2]),
            .suffix    (suffix[i*SUF_W +: SUF_W])
        );
    end

endmodule

// File: tb/tb_cuckoo_lookup_pipe.sv
// Scoreboard bench for cuckoo_lookup_pipe: directed lookups with hand-computed
// hash addresses; a negedge monitor checks results and their enabled-cycle timing.
module tb_cuckoo_lookup_pipe;

    localparam int NUM_CH = 2;
    localparam int HASH_W = 10;
    localparam int IDX_W  = 9;
    localparam int KEY_W  = 8;
    localparam int SUF_W  = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     enable = 1'b1;
    logic [NUM_CH-1:0]        in_valid = '0;
    logic [NUM_CH*HASH_W-1:0] pre_t1 = '0;
    logic [NUM_CH*HASH_W-1:0] pre_t2 = '0;
    logic [NUM_CH*KEY_W-1:0]  hash_byte = '0;
    logic [NUM_CH*KEY_W-1:0]  cmp_byte = '0;
    logic                     cfg_we = 1'b0;
    logic                     cfg_sel = 1'b0;
    logic                     cfg_ch = 1'b0;
    logic [HASH_W:0]          cfg_addr = '0;
    logic [9:0]               cfg_data = '0;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH*2-1:0]      hit;
    logic [NUM_CH*SUF_W-1:0]  suffix;

    typedef struct {
        logic [1:0] hit;
        logic [1:0] suf;
        int         due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   en_cnt = 0;
    logic adv    = 1'b0;

    cuckoo_lookup_pipe #(
        .NUM_CH (NUM_CH),
        .HASH_W (HASH_W),
        .IDX_W  (IDX_W),
        .KEY_W  (KEY_W),
        .SUF_W  (SUF_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid),
        .pre_t1    (pre_t1),
        .pre_t2    (pre_t2),
        .hash_byte (hash_byte),
        .cmp_byte  (cmp_byte),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_ch    (cfg_ch),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .out_valid (out_valid),
        .hit       (hit),
        .suffix    (suffix)
    );

    always #5 clk = ~clk;

    // Count enabled, non-reset edges; results are due a fixed number of these after issue.
    always @(posedge clk) begin
        adv <= enable && !rst;
        if (enable && !rst) en_cnt <= en_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: after each enabled edge, pop and compare any presented result.
    always @(negedge clk) begin
        if (adv) begin
            for (int c = 0; c < NUM_CH; c++) begin
                logic [1:0] h;
                logic [1:0] s;
                exp_t       e;
                bit         have;
                h = hit[c*2 +: 2];
                s = suffix[c*SUF_W +: SUF_W];
                have = 1'b0;
                if (out_valid[c]) begin
                    if (c == 0 && q0.size() > 0) begin
                        e = q0.pop_front();
                        have = 1'b1;
                    end else if (c == 1 && q1.size() > 0) begin
                        e = q1.pop_front();
                        have = 1'b1;
                    end
                    if (!have) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_result ch%0d: got out_valid=1, expected none (t=%0t)", c, $time);
                    end else begin
                        check($sformatf("hit_ch%0d", c), 32'(h), 32'(e.hit));
                        check($sformatf("suffix_ch%0d", c), 32'(s), 32'(e.suf));
                        check($sformatf("latency_ch%0d", c), 32'(en_cnt), 32'(e.due));
                    end
                end else begin
                    check($sformatf("idle_zero_ch%0d", c), 32'({h, s}), 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int ch, input logic [9:0] p1, input logic [9:0] p2,
                       input logic [7:0] hb, input logic [7:0] cb,
                       input bit expect_out, input logic [1:0] eh, input logic [1:0] es);
        exp_t e;
        in_valid[ch] = 1'b1;
        pre_t1[ch*HASH_W +: HASH_W]  = p1;
        pre_t2[ch*HASH_W +: HASH_W]  = p2;
        hash_byte[ch*KEY_W +: KEY_W] = hb;
        cmp_byte[ch*KEY_W +: KEY_W]  = cb;
        if (expect_out) begin
            e.hit = eh;
            e.suf = es;
            e.due = en_cnt + 4;
            if (ch == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic idle();
        in_valid = '0;
    endtask

    task automatic cfg(input logic sel, input logic ch, input logic [10:0] addr, input logic [9:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_ch   = ch;
        cfg_addr = addr;
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Pattern A: pre_t1=0x010, pre_t2=0x020, hb=0x00 -> h1=0x092, h2=0x124 (L1 0x092 / 0x524).
    // Pattern B: pre_t1=0x3FF, pre_t2=0x155, hb=0xFF -> h1=0x289, h2=0x284 (L1 0x289 / 0x684).
    initial begin
        tick();
        tick();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_hit", 32'(hit), 32'd0);
        check("reset_suffix", 32'(suffix), 32'd0);
        rst = 1'b0;

        cfg(1'b0, 1'b0, 11'h092, 10'd5);
        cfg(1'b0, 1'b0, 11'h524, 10'd7);
        cfg(1'b1, 1'b0, 11'd5,   10'h106);   // {0x41, 2'b10}
        cfg(1'b1, 1'b0, 11'd7,   10'h109);   // {0x42, 2'b01}
        cfg(1'b0, 1'b0, 11'h289, 10'd9);
        cfg(1'b0, 1'b0, 11'h684, 10'd10);
        cfg(1'b1, 1'b0, 11'd9,   10'h1DF);   // {0x77, 2'b11}
        cfg(1'b1, 1'b0, 11'd10,  10'h1DD);   // {0x77, 2'b01}
        cfg(1'b0, 1'b1, 11'h092, 10'd5);
        cfg(1'b0, 1'b1, 11'h524, 10'd7);
        cfg(1'b1, 1'b1, 11'd5,   10'h105);   // {0x41, 2'b01}
        cfg(1'b1, 1'b1, 11'd7,   10'h10F);   // {0x43, 2'b11}

        // Way A hit, way B hit, miss, both-way hit (back to back).
        req(0, 10'h010, 10'h020, 8'h00, 8'h41, 1'b1, 2'b01, 2'b10);
        tick();
        req(0, 10'h010, 10'h020, 8'h00, 8'h42, 1'b1, 2'b10, 2'b01);
        tick();
        req(0, 10'h010, 10'h020, 8'h00, 8'h99, 1'b1, 2'b00, 2'b00);
        tick();
        req(0, 10'h3FF, 10'h155, 8'hFF, 8'h77, 1'b1, 2'b11, 2'b11);
        tick();
        idle();
        ticks(6);

        // Same key, per-channel suffixes.
        req(0, 10'h010, 10'h020, 8'h00, 8'h41, 1'b1, 2'b01, 2'b10);
        req(1, 10'h010, 10'h020, 8'h00, 8'h41, 1'b1, 2'b01, 2'b01);
        tick();
        idle();
        ticks(6);

        // Four requests with a two-cycle enable gap mid-stream.
        req(0, 10'h010, 10'h020, 8'h00, 8'h41, 1'b1, 2'b01, 2'b10);
        tick();
        req(0, 10'h010, 10'h020, 8'h00, 8'h42, 1'b1, 2'b10, 2'b01);
        tick();
        idle();
        enable = 1'b0;
        ticks(2);
        enable = 1'b1;
        req(0, 10'h3FF, 10'h155, 8'hFF, 8'h77, 1'b1, 2'b11, 2'b11);
        tick();
        req(0, 10'h010, 10'h020, 8'h00, 8'h99, 1'b1, 2'b00, 2'b00);
        tick();
        idle();
        ticks(8);

        // Outputs hold while enable is low.
        req(0, 10'h010, 10'h020, 8'h00, 8'h42, 1'b1, 2'b10, 2'b01);
        tick();
        idle();
        ticks(3);
        enable = 1'b0;
        ticks(2);
        check("hold_out_valid", 32'(out_valid), 32'd1);
        check("hold_hit", 32'(hit), 32'h2);
        check("hold_suffix", 32'(suffix), 32'h1);
        enable = 1'b1;
        ticks(2);

        // Reset with three requests in flight, plus a T3 write during reset.
        req(0, 10'h010, 10'h020, 8'h00, 8'h41, 1'b0, 2'b00, 2'b00);
        tick();
        req(0, 10'h010, 10'h020, 8'h00, 8'h42, 1'b0, 2'b00, 2'b00);
        tick();
        req(0, 10'h3FF, 10'h155, 8'hFF, 8'h77, 1'b0, 2'b00, 2'b00);
        tick();
        idle();
        rst = 1'b1;
        cfg(1'b1, 1'b0, 11'd5, 10'h1FF);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post_reset_out_valid_%0d", i), 32'(out_valid), 32'd0);
        end
        req(0, 10'h010, 10'h020, 8'h00, 8'h41, 1'b1, 2'b01, 2'b10);
        tick();
        idle();
        ticks(6);

        // T3 write colliding with the stage-3 read of the same address.
        req(0, 10'h010, 10'h020, 8'h00, 8'h41, 1'b1, 2'b01, 2'b10);
        tick();
        idle();
        tick();
        cfg(1'b1, 1'b0, 11'd5, 10'h107);     // {0x41, 2'b11}
        ticks(4);
        req(0, 10'h010, 10'h020, 8'h00, 8'h41, 1'b1, 2'b01, 2'b11);
        tick();
        idle();
        ticks(6);

        for (int i = 0; i < 20 && (q0.size() > 0 || q1.size() > 0); i++) tick();
        if (q0.size() > 0 || q1.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d/%0d results outstanding, expected 0/0", q0.size(), q1.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
